pixel_gen_multi: RTL and testbench
==================================

PIXEL_GEN_MULTI -- requirements
Module: pixel_gen_multi

Parameters
REQ-001 SHALL have parameter NUM_BALLS, default 4, number of ball channels (legal 1..8).
REQ-002 SHALL have parameter TOP_MARGIN, default 25, header height in lines.
REQ-003 SHALL have parameter PADDLE_H, default 72, paddle height minus one in lines.
REQ-004 SHALL have parameter FLASH_FRAMES, default 8, paddle hit-flash duration in frames (legal 1..15).
REQ-005 SHALL have colour parameters WALL_COLOR 12'h89C, PADDLE_COLOR 12'h24F, FLASH_COLOR 12'hFFF, HEADER_BG_COLOR 12'h135.

Interface
REQ-006 SHALL have port clk, input, 1, pixel clock; one clock domain only.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports x, y, input, 10 each, current scan position.
REQ-009 SHALL have port video_on, input, 1, active-display flag.
REQ-010 SHALL have port frame_tick, input, 1, one-cycle pulse per frame.
REQ-011 SHALL have ports ball_x, ball_y, input, 10*NUM_BALLS each, packed ball top-left positions; ball i occupies bits [10i+9:10i].
REQ-012 SHALL have port ball_en, input, NUM_BALLS, per-ball visibility mask.
REQ-013 SHALL have ports paddle1_y, paddle2_y, input, 10 each, paddle top relative to TOP_MARGIN.
REQ-014 SHALL have ports bg_pixel, game_over_pixel, text_rgb, input, 12 each; text_on, game_over, input, 1 each.
REQ-015 SHALL have port ball_speed, input, 4, speed level for ball colour.
REQ-016 SHALL have ports hit_p1, hit_p2, input, 1 each, one-cycle paddle-hit pulses.
REQ-017 SHALL have port rgb, output, 12, registered pixel colour.

Function
REQ-018 Pipeline: 2 stages; inputs sampled at edge N SHALL determine rgb after edge N+1, latency 2 cycles, one pixel per cycle, no stalls.
REQ-019 Stage 1 SHALL register region hits (header, walls, paddles, per-ball square hit and sprite row/column), video_on, game_over, text_on and all colour inputs needed by stage 2.
REQ-020 Ball i square hit: ball_x_i <= x <= ball_x_i+7 and ball_y_i <= y <= ball_y_i+7, evaluated in 11-bit arithmetic so positions 1017..1023 SHALL NOT wrap.
REQ-021 Ball sprite SHALL be 8x8 circle, rows 0..7 = 3C,7E,FF,FF,FF,FF,7E,3C; bit index = x-ball_x; each ball uses its own row, with no shared-ROM aliasing between balls.
REQ-022 Ball i visible only if ball_en[i]=1 and sprite bit set; overlapping balls: lowest index wins.
REQ-023 Ball colour from ball_speed: 2->12'h012, 3->12'h880, 4->12'h080, 5->12'h800, others->12'h012.
REQ-024 Priority, highest first: ~video_on->000; game_over->game_over_pixel; y<TOP_MARGIN->text_rgb if text_on else HEADER_BG_COLOR; x<32 or x>608->WALL_COLOR; paddle1 (32<=x<=40) / paddle2 (600<=x<=608), with paddle_y+TOP_MARGIN <= y <= paddle_y+TOP_MARGIN+PADDLE_H -> paddle colour; visible ball; else bg_pixel.
REQ-025 Per paddle, a 4-bit flash counter SHALL load FLASH_FRAMES on hit pulse and decrement by 1 on frame_tick while nonzero; it saturates at 0.
REQ-026 Hit pulse and frame_tick in the same cycle: load SHALL win.
REQ-027 Paddle colour SHALL be FLASH_COLOR while its counter is nonzero, else PADDLE_COLOR.
REQ-028 game_over=1 SHALL clear both flash counters on the next edge.

Reset
REQ-029 On reset at an edge: rgb=12'h000, all stage-1 registers and flash counters = 0; rgb SHALL stay 000 for 2 cycles after reset deasserts, irrespective of inputs.
REQ-030 Reset asserted mid-frame or mid-flash SHALL abort the flash; there SHALL be no residual colour.

Verification
REQ-031 Latency: video_on=1, x=100, y=100, bg_pixel=12'hABC, no objects -> rgb=12'hABC exactly 2 cycles after inputs applied; video_on=0 -> 000 2 cycles later.
REQ-032 Ball mask: NUM_BALLS=4, ball 2 at (200,200), ball_en=4'b0100, speed 4, pixel (203,200) -> 12'h080; pixel (200,200) (sprite corner) -> bg; ball_en=0 -> bg.
REQ-033 Priority: ball at (20,100) with x=22, y=102 -> WALL_COLOR; game_over=1 anywhere visible -> game_over_pixel; y=10, text_on=1 -> text_rgb.
REQ-034 Flash: hit_p1 pulse, then 8 frame_ticks; paddle1 pixel (36, paddle1_y+25) -> FFF through tick 7, 24F after tick 8; hit coincident with tick reloads to 8.
REQ-035 Boundary: ball_x=1020, x=1023 -> square hit with no wrap; ball_x=1020, x=3 -> no hit; paddle1_y=0, y=25 and y=97 hit, y=98 miss.
REQ-036 Reset during flash (counter=5) -> counter 0, rgb 000 for 2 cycles, then paddle shown as 24F.

Source files
------------

// File: rtl/pixel_gen_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_gen_multi : 2-stage pixel colour pipeline for multi-ball pong      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pixel_gen_multi #(
  parameter int          NUM_BALLS       = 4,
  parameter int          TOP_MARGIN      = 25,
  parameter int          PADDLE_H        = 72,
  parameter int          FLASH_FRAMES    = 8,
  parameter logic [11:0] WALL_COLOR      = 12'h89C,
  parameter logic [11:0] PADDLE_COLOR    = 12'h24F,
  parameter logic [11:0] FLASH_COLOR     = 12'hFFF,
  parameter logic [11:0] HEADER_BG_COLOR = 12'h135
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              x,
  input  logic [9:0]              y,
  input  logic                    video_on,
  input  logic                    frame_tick,
  input  logic [10*NUM_BALLS-1:0] ball_x,
  input  logic [10*NUM_BALLS-1:0] ball_y,
  input  logic [NUM_BALLS-1:0]    ball_en,
  input  logic [9:0]              paddle1_y,
  input  logic [9:0]              paddle2_y,
  input  logic [11:0]             bg_pixel,
  input  logic [11:0]             game_over_pixel,
  input  logic [11:0]             text_rgb,
  input  logic                    text_on,
  input  logic                    game_over,
  input  logic [3:0]              ball_speed,
  input  logic                    hit_p1,
  input  logic                    hit_p2,
  output logic [11:0]             rgb
);

  localparam logic [11:0] c_top      = 12'(TOP_MARGIN);
  localparam logic [11:0] c_pad_h    = 12'(PADDLE_H);
  localparam logic [3:0]  c_flash    = 4'(FLASH_FRAMES);
  localparam logic [9:0]  c_wall_l   = 10'd32;
  localparam logic [9:0]  c_wall_r   = 10'd608;
  localparam logic [9:0]  c_pad1_l   = 10'd32;
  localparam logic [9:0]  c_pad1_r   = 10'd40;
  localparam logic [9:0]  c_pad2_l   = 10'd600;
  localparam logic [9:0]  c_pad2_r   = 10'd608;

  // Each ball looks up its own row/column, so no ROM is shared between balls.
  function automatic logic sprite_bit(input logic [2:0] row, input logic [2:0] col);
    logic [7:0] bits;
    case (row)
      3'd0, 3'd7: bits = 8'h3C;
      3'd1, 3'd6: bits = 8'h7E;
      default:    bits = 8'hFF;
    endcase
    return bits[col];
  endfunction

  // Stage-1 registers
  logic                          header_d,  header_q;
  logic                          wall_d,    wall_q;
  logic                          pad1_d,    pad1_q;
  logic                          pad2_d,    pad2_q;
  logic [NUM_BALLS-1:0]          ball_hit_d, ball_hit_q;
  logic [NUM_BALLS-1:0][2:0]     ball_row_d, ball_row_q;
  logic [NUM_BALLS-1:0][2:0]     ball_col_d, ball_col_q;
  logic                          video_on_d, video_on_q;
  logic                          game_over_d, game_over_q;
  logic                          text_on_d, text_on_q;
  logic [11:0]                   bg_d,      bg_q;
  logic [11:0]                   go_pix_d,  go_pix_q;
  logic [11:0]                   text_d,    text_q;
  logic [11:0]                   ball_color_d, ball_color_q;

  // Flash counters and stage-2 output
  logic [3:0]                    flash1_d,  flash1_q;
  logic [3:0]                    flash2_d,  flash2_q;
  logic [11:0]                   rgb_d,     rgb_q;

  logic [11:0]                   w_y12;
  logic [11:0]                   w_p1_top;
  logic [11:0]                   w_p2_top;
  logic                          w_ball_vis;

  assign w_y12    = {2'b00, y};
  assign w_p1_top = {2'b00, paddle1_y} + c_top;
  assign w_p2_top = {2'b00, paddle2_y} + c_top;

  always_comb begin
    header_d    = (w_y12 < c_top);
    wall_d      = (x < c_wall_l) || (x > c_wall_r);
    pad1_d      = (x >= c_pad1_l) && (x <= c_pad1_r) &&
                  (w_y12 >= w_p1_top) && (w_y12 <= w_p1_top + c_pad_h);
    pad2_d      = (x >= c_pad2_l) && (x <= c_pad2_r) &&
                  (w_y12 >= w_p2_top) && (w_y12 <= w_p2_top + c_pad_h);
    video_on_d  = video_on;
    game_over_d = game_over;
    text_on_d   = text_on;
    bg_d        = bg_pixel;
    go_pix_d    = game_over_pixel;
    text_d      = text_rgb;
    case (ball_speed)
      4'd3:    ball_color_d = 12'h880;
      4'd4:    ball_color_d = 12'h080;
      4'd5:    ball_color_d = 12'h800;
      default: ball_color_d = 12'h012;
    endcase
  end

  // 11-bit compares keep positions near 1023 from wrapping onto the left edge.
  always_comb begin
    ball_hit_d = '0;
    ball_row_d = '0;
    ball_col_d = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      logic [9:0] bx, by, dx, dy;
      bx = ball_x[i*10 +: 10];
      by = ball_y[i*10 +: 10];
      dx = x - bx;
      dy = y - by;
      ball_hit_d[i] = ball_en[i] &&
                      ({1'b0, x} >= {1'b0, bx}) && ({1'b0, x} <= {1'b0, bx} + 11'd7) &&
                      ({1'b0, y} >= {1'b0, by}) && ({1'b0, y} <= {1'b0, by} + 11'd7);
      ball_col_d[i] = dx[2:0];
      ball_row_d[i] = dy[2:0];
    end
  end

  // game_over clears, then a hit reloads (beating a coincident tick), then tick decrements.
  always_comb begin
    flash1_d = flash1_q;
    flash2_d = flash2_q;
    if (game_over) begin
      flash1_d = 4'd0;
      flash2_d = 4'd0;
    end else begin
      if (hit_p1)
        flash1_d = c_flash;
      else if (frame_tick && (flash1_q != 4'd0))
        flash1_d = flash1_q - 4'd1;
      if (hit_p2)
        flash2_d = c_flash;
      else if (frame_tick && (flash2_q != 4'd0))
        flash2_d = flash2_q - 4'd1;
    end
  end

  always_comb begin
    w_ball_vis = 1'b0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      w_ball_vis = w_ball_vis | (ball_hit_q[i] & sprite_bit(ball_row_q[i], ball_col_q[i]));
    end
  end

  always_comb begin
    rgb_d = bg_q;
    if (!video_on_q)
      rgb_d = 12'h000;
    else if (game_over_q)
      rgb_d = go_pix_q;
    else if (header_q)
      rgb_d = text_on_q ? text_q : HEADER_BG_COLOR;
    else if (wall_q)
      rgb_d = WALL_COLOR;
    else if (pad1_q)
      rgb_d = (flash1_q != 4'd0) ? FLASH_COLOR : PADDLE_COLOR;
    else if (pad2_q)
      rgb_d = (flash2_q != 4'd0) ? FLASH_COLOR : PADDLE_COLOR;
    else if (w_ball_vis)
      rgb_d = ball_color_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      header_q     <= 1'b0;
      wall_q       <= 1'b0;
      pad1_q       <= 1'b0;
      pad2_q       <= 1'b0;
      ball_hit_q   <= '0;
      ball_row_q   <= '0;
      ball_col_q   <= '0;
      video_on_q   <= 1'b0;
      game_over_q  <= 1'b0;
      text_on_q    <= 1'b0;
      bg_q         <= 12'h000;
      go_pix_q     <= 12'h000;
      text_q       <= 12'h000;
      ball_color_q <= 12'h000;
      flash1_q     <= 4'd0;
      flash2_q     <= 4'd0;
      rgb_q        <= 12'h000;
    end else begin
      header_q     <= header_d;
      wall_q       <= wall_d;
      pad1_q       <= pad1_d;
      pad2_q       <= pad2_d;
      ball_hit_q   <= ball_hit_d;
      ball_row_q   <= ball_row_d;
      ball_col_q   <= ball_col_d;
      video_on_q   <= video_on_d;
      game_over_q  <= game_over_d;
      text_on_q    <= text_on_d;
      bg_q         <= bg_d;
      go_pix_q     <= go_pix_d;
      text_q       <= text_d;
      ball_color_q <= ball_color_d;
      flash1_q     <= flash1_d;
      flash2_q     <= flash2_d;
      rgb_q        <= rgb_d;
    end
  end

  assign rgb = rgb_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_gen_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pixel_gen_multi : self-checking bench for pixel_gen_multi             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pixel_gen_multi;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    x, y;
  logic          video_on, frame_tick, text_on, game_over;
  logic [10*NB-1:0] ball_x, ball_y;
  logic [NB-1:0] ball_en;
  logic [9:0]    paddle1_y, paddle2_y;
  logic [11:0]   bg_pixel, game_over_pixel, text_rgb;
  logic [3:0]    ball_speed;
  logic          hit_p1, hit_p2;
  logic [11:0]   rgb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pixel_gen_multi dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
    .frame_tick(frame_tick), .ball_x(ball_x), .ball_y(ball_y), .ball_en(ball_en),
    .paddle1_y(paddle1_y), .paddle2_y(paddle2_y), .bg_pixel(bg_pixel),
    .game_over_pixel(game_over_pixel), .text_rgb(text_rgb), .text_on(text_on),
    .game_over(game_over), .ball_speed(ball_speed), .hit_p1(hit_p1),
    .hit_p2(hit_p2), .rgb(rgb)
  );

  typedef struct {
    logic [9:0]  x, y;
    logic        vo, go, ton;
    logic [39:0] bx, by;
    logic [3:0]  en, spd;
    logic [9:0]  p1, p2;
    logic [11:0] bg, gop, txt;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t base();
    vec_t v;
    v.x = 10'd100; v.y = 10'd100; v.vo = 1'b1; v.go = 1'b0; v.ton = 1'b0;
    v.bx = '0; v.by = '0; v.en = 4'd0; v.spd = 4'd4;
    v.p1 = 10'd300; v.p2 = 10'd300;
    v.bg = 12'hABC; v.gop = 12'hD0D; v.txt = 12'h5A5; v.exp = 12'hABC;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    x = v.x; y = v.y; video_on = v.vo; game_over = v.go; text_on = v.ton;
    ball_x = v.bx; ball_y = v.by; ball_en = v.en; ball_speed = v.spd;
    paddle1_y = v.p1; paddle2_y = v.p2;
    bg_pixel = v.bg; game_over_pixel = v.gop; text_rgb = v.txt;
  endtask

  task automatic check(input string name, input logic [11:0] exp);
    checks++;
    if (rgb !== exp) begin
      errors++;
      $display("FAIL %s: rgb=%h expected=%h", name, rgb, exp);
    end
  endtask

  // Reference model: geometric circle test and plain integer region rules.
  function automatic bit in_circle(int c, int r);
    int dx, dy;
    dx = 2*c - 7;
    dy = 2*r - 7;
    return (dx*dx + dy*dy) <= 60;
  endfunction

  function automatic logic [11:0] speed_color(logic [3:0] s);
    if (s == 4'd3) return 12'h880;
    if (s == 4'd4) return 12'h080;
    if (s == 4'd5) return 12'h800;
    return 12'h012;
  endfunction

  function automatic logic [11:0] ref_color(vec_t s, int f1, int f2);
    int xi, yi;
    xi = int'(s.x);
    yi = int'(s.y);
    if (!s.vo) return 12'h000;
    if (s.go) return s.gop;
    if (yi < 25) return s.ton ? s.txt : 12'h135;
    if (xi < 32 || xi > 608) return 12'h89C;
    if (xi >= 32 && xi <= 40 && yi >= int'(s.p1) + 25 && yi <= int'(s.p1) + 97)
      return (f1 != 0) ? 12'hFFF : 12'h24F;
    if (xi >= 600 && xi <= 608 && yi >= int'(s.p2) + 25 && yi <= int'(s.p2) + 97)
      return (f2 != 0) ? 12'hFFF : 12'h24F;
    for (int i = 0; i < NB; i++) begin
      int c, r;
      c = xi - int'(s.bx[i*10 +: 10]);
      r = yi - int'(s.by[i*10 +: 10]);
      if (s.en[i] && c >= 0 && c <= 7 && r >= 0 && r <= 7 && in_circle(c, r))
        return speed_color(s.spd);
    end
    return s.bg;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v = base();
    case ($urandom % 4)
      0: v.x = 10'($urandom_range(28, 44));
      1: v.x = 10'($urandom_range(596, 612));
      default: v.x = 10'($urandom_range(0, 639));
    endcase
    v.y = ($urandom % 8 == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 479));
    v.vo  = ($urandom % 8) != 0;
    v.go  = ($urandom % 16) == 0;
    v.ton = 1'($urandom);
    v.en  = 4'($urandom);
    v.spd = 4'($urandom);
    v.p1  = ($urandom % 2 == 0) ? 10'(int'(v.y) - int'($urandom_range(0, 100))) : 10'($urandom_range(0, 400));
    v.p2  = ($urandom % 2 == 0) ? 10'(int'(v.y) - int'($urandom_range(0, 100))) : 10'($urandom_range(0, 400));
    v.bg  = 12'($urandom); v.gop = 12'($urandom); v.txt = 12'($urandom);
    for (int i = 0; i < NB; i++) begin
      v.bx[i*10 +: 10] = ($urandom % 4 != 0) ? 10'(int'(v.x) - int'($urandom_range(0, 9))) : 10'($urandom);
      v.by[i*10 +: 10] = ($urandom % 4 != 0) ? 10'(int'(v.y) - int'($urandom_range(0, 9))) : 10'($urandom);
    end
    return v;
  endfunction

  task automatic pulse(input logic h1, input logic ft, input logic go);
    @(negedge clk);
    hit_p1 = h1; frame_tick = ft; game_over = go;
    @(negedge clk);
    hit_p1 = 1'b0; frame_tick = 1'b0; game_over = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t v, fv;
    int f1, f2;
    logic [11:0] prev_exp, exp_k;

    reset = 1'b1; hit_p1 = 1'b0; hit_p2 = 1'b0; frame_tick = 1'b0;
    apply(base());
    repeat (3) @(posedge clk);
    #1 check("reset_rgb", 12'h000);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1 check("post_reset_hold", 12'h000);
    @(posedge clk); #1 check("latency_bg", 12'hABC);

    // Directed vectors
    v = base();                                     vecs.push_back(v);
    v = base(); v.vo = 0; v.exp = 12'h000;          vecs.push_back(v);
    v = base(); v.bx[29:20] = 200; v.by[29:20] = 200; v.en = 4'b0100; v.spd = 4;
    v.x = 203; v.y = 200; v.exp = 12'h080;          vecs.push_back(v);
    v.x = 200; v.exp = 12'hABC;                     vecs.push_back(v);
    v.x = 203; v.en = 0; v.exp = 12'hABC;           vecs.push_back(v);
    v = base(); v.bx[9:0] = 20; v.by[9:0] = 100; v.en = 1; v.x = 22; v.y = 102;
    v.exp = 12'h89C;                                vecs.push_back(v);
    v = base(); v.go = 1; v.exp = 12'hD0D;          vecs.push_back(v);
    v = base(); v.y = 10; v.ton = 1; v.exp = 12'h5A5; vecs.push_back(v);
    v.ton = 0; v.exp = 12'h135;                     vecs.push_back(v);
    v = base(); v.bx[9:0] = 300; v.by[9:0] = 1020; v.en = 1; v.spd = 3;
    v.x = 303; v.y = 1022; v.exp = 12'h880;         vecs.push_back(v);
    v = base(); v.bx[9:0] = 300; v.by[9:0] = 300; v.en = 1; v.spd = 5;
    v.x = 307; v.y = 303; v.exp = 12'h800;          vecs.push_back(v);
    v.x = 308; v.exp = 12'hABC;                     vecs.push_back(v);
    v.x = 301; v.y = 300; v.exp = 12'hABC;          vecs.push_back(v);
    v.x = 302; v.exp = 12'h800;                     vecs.push_back(v);
    v = base(); v.p1 = 0; v.x = 36; v.y = 25; v.exp = 12'h24F; vecs.push_back(v);
    v.y = 97; v.exp = 12'h24F;                      vecs.push_back(v);
    v.y = 98; v.exp = 12'hABC;                      vecs.push_back(v);
    v.y = 50; v.x = 32; v.exp = 12'h24F;            vecs.push_back(v);
    v.x = 31; v.exp = 12'h89C;                      vecs.push_back(v);
    v.x = 41; v.exp = 12'hABC;                      vecs.push_back(v);
    v = base(); v.p2 = 100; v.x = 608; v.y = 125; v.exp = 12'h24F; vecs.push_back(v);
    v.x = 609; v.exp = 12'h89C;                     vecs.push_back(v);
    v.x = 600; v.y = 197; v.exp = 12'h24F;          vecs.push_back(v);
    v.y = 198; v.exp = 12'hABC;                     vecs.push_back(v);
    v = base(); v.bx[9:0] = 300; v.by[9:0] = 300; v.bx[19:10] = 300; v.by[19:10] = 300;
    v.en = 4'b0010; v.spd = 7; v.x = 300; v.y = 300; v.exp = 12'hABC; vecs.push_back(v);
    v.en = 4'b0011; v.x = 303; v.y = 303; v.exp = 12'h012; vecs.push_back(v);
    v.spd = 2; v.exp = 12'h012;                     vecs.push_back(v);

    foreach (vecs[i]) begin
      @(negedge clk) apply(vecs[i]);
      @(posedge clk); @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Flash sequence on paddle 1
    fv = base(); fv.p1 = 50; fv.x = 36; fv.y = 75;
    @(negedge clk) apply(fv);
    pulse(1, 0, 0); check("flash_load", 12'hFFF);
    for (int t = 1; t <= 8; t++) begin
      pulse(0, 1, 0);
      check($sformatf("flash_tick%0d", t), (t <= 7) ? 12'hFFF : 12'h24F);
    end
    pulse(1, 0, 0);
    repeat (3) pulse(0, 1, 0);
    pulse(1, 1, 0); check("flash_reload", 12'hFFF);
    for (int t = 1; t <= 8; t++) begin
      pulse(0, 1, 0);
      check($sformatf("reload_tick%0d", t), (t <= 7) ? 12'hFFF : 12'h24F);
    end
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    @(posedge clk); #1 check("game_over_clears_flash", 12'h24F);

    // Reset while the counter sits at 5
    pulse(1, 0, 0);
    repeat (3) pulse(0, 1, 0);
    check("flash_at_5", 12'hFFF);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 check("mid_flash_reset", 12'h000);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1 check("reset_hold1", 12'h000);
    @(posedge clk); #1 check("reset_no_flash", 12'h24F);

    // Randomized stream against the reference model
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    f1 = 0; f2 = 0; prev_exp = 12'h000;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      v = rand_vec();
      apply(v);
      hit_p1 = ($urandom % 10) == 0;
      hit_p2 = ($urandom % 10) == 0;
      frame_tick = ($urandom % 4) == 0;
      if (v.go) begin f1 = 0; f2 = 0; end
      else begin
        if (hit_p1) f1 = 8; else if (frame_tick && f1 > 0) f1 = f1 - 1;
        if (hit_p2) f2 = 8; else if (frame_tick && f2 > 0) f2 = f2 - 1;
      end
      exp_k = ref_color(v, f1, f2);
      @(posedge clk); #1;
      if (k > 0) check($sformatf("rand%0d", k), prev_exp);
      prev_exp = exp_k;
    end
    @(negedge clk);
    hit_p1 = 1'b0; hit_p2 = 1'b0; frame_tick = 1'b0;
    @(posedge clk); #1 check("rand_last", prev_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
